wb_mem_responder: RTL



---
 rtl/wb_mem_responder_pkg.sv | 14 +
 rtl/wb_mem_responder_ram.sv | 40 ++++
 rtl/wb_mem_responder.sv | 116 +++++++++++
 3 files changed

// File: rtl/wb_mem_responder_pkg.sv
// Shared types and bus widths for the Wishbone memory responder.
package wb_mem_responder_pkg;

    localparam int DATA_W = 32;
    localparam int SEL_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2,
        GAP  = 2'd3
    } state_t;

endpackage

// File: rtl/wb_mem_responder_ram.sv
// DEPTH x 32 byte-enable word RAM: asynchronous clear, single-cycle write,
// combinational read (the parent registers the read result).
module wb_mem_responder_ram
    import wb_mem_responder_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_we,
    input  logic [AW-1:0]     i_idx,
    input  logic [DATA_W-1:0] i_dat,
    input  logic [SEL_W-1:0]  i_sel,
    output logic [DATA_W-1:0] o_rdat
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Byte-lane write of the selected word; whole array clears on reset.
    // NOTE: every word is reset because the bus contract promises zeroed
    // memory after reset; this keeps the array in flops, not an SRAM macro.
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            for (int k = 0; k < SEL_W; k++) begin
                if (i_sel[k]) begin
                    r_mem[i_idx][8*k +: 8] <= i_dat[8*k +: 8];
                end
            end
        end
    end

    assign o_rdat = r_mem[i_idx];

endmodule

// File: rtl/wb_mem_responder.sv
// Wishbone-style memory responder: request capture, IDLE/WAIT/ACK/GAP FSM,
// wait states from i_stall. Optional macro WB_MEM_RESPONDER_FAIRNESS_EN adds
// a stall counter that forces an ack after MAX_STALL stalled WAIT cycles.
module wb_mem_responder
    import wb_mem_responder_pkg::*;
#(
    parameter  int DEPTH     = 16,
    parameter  int MAX_STALL = 7,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] i_wb_adr,
    input  logic [DATA_W-1:0] i_wb_dat,
    input  logic [SEL_W-1:0]  i_wb_sel,
    input  logic              i_wb_we,
    input  logic              i_wb_cyc,
    input  logic              i_stall,
    output logic [DATA_W-1:0] o_wb_rdt,
    output logic              o_wb_ack
);

    state_t            r_state;
    logic [AW-1:0]     r_idx;
    logic [DATA_W-1:0] r_dat;
    logic [SEL_W-1:0]  r_sel;
    logic              r_we;

    logic              w_force_ack;
    logic              w_go_ack;
    logic              w_ram_we;
    logic [DATA_W-1:0] w_ram_rdat;

    // Address bits outside the word index are ignored (aliasing).
    logic w_unused_adr;
    assign w_unused_adr = ^{i_wb_adr[DATA_W-1:AW+2], i_wb_adr[1:0]};

`ifdef WB_MEM_RESPONDER_FAIRNESS_EN
    localparam int STALL_W = $clog2(MAX_STALL + 1);

    logic [STALL_W-1:0] r_stall_cnt;

    // Count stalled WAIT cycles; clear whenever WAIT is left or not occupied.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (r_state == WAIT && i_wb_cyc && !w_go_ack) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end else begin
            r_stall_cnt <= '0;
        end
    end

    assign w_force_ack = (r_stall_cnt == STALL_W'(MAX_STALL));
`else
    logic w_unused_max_stall;
    assign w_unused_max_stall = 1'(MAX_STALL);
    assign w_force_ack        = 1'b0;
`endif

    // A live, un-aborted WAIT cycle completes when not stalled (or forced).
    assign w_go_ack = (r_state == WAIT) && i_wb_cyc && (!i_stall || w_force_ack);
    assign w_ram_we = w_go_ack && r_we;

    wb_mem_responder_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clock  (clock),
        .reset  (reset),
        .i_we   (w_ram_we),
        .i_idx  (r_idx),
        .i_dat  (r_dat),
        .i_sel  (r_sel),
        .o_rdat (w_ram_rdat)
    );

    // Request/ack FSM with captured request and registered rdt/ack.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_dat    <= '0;
            r_sel    <= '0;
            r_we     <= 1'b0;
            o_wb_ack <= 1'b0;
            o_wb_rdt <= '0;
        end else begin
            o_wb_ack <= 1'b0;
            o_wb_rdt <= '0;
            case (r_state)
                IDLE: begin
                    if (i_wb_cyc) begin
                        r_idx   <= i_wb_adr[AW+1:2];
                        r_dat   <= i_wb_dat;
                        r_sel   <= i_wb_sel;
                        r_we    <= i_wb_we;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (!i_wb_cyc) begin
                        r_state <= IDLE;
                    end else if (w_go_ack) begin
                        o_wb_ack <= 1'b1;
                        o_wb_rdt <= r_we ? '0 : w_ram_rdat;
                        r_state  <= ACK;
                    end
                end
                ACK:     r_state <= GAP;
                GAP:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
